// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - bank of runtime-programmable 50% duty clock dividers with tick enables
module clk_div_bank #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 1,
    parameter int CH_W        = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              sync_i,
    input  logic              load_valid_i,
    input  logic [CH_W-1:0]   load_ch_i,
    input  logic [CNT_W-1:0]  load_div_i,
    output logic              load_ready_o,
    output logic [NUM_CH-1:0] clk_out_o,
    output logic [NUM_CH-1:0] tick_o
);

    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0] div_q, div_d;
    logic [NUM_CH-1:0][CNT_W-1:0] shadow_q, shadow_d;
    logic [NUM_CH-1:0]            pending_q, pending_d;
    logic [NUM_CH-1:0]            clk_q, clk_d;
    logic [NUM_CH-1:0]            tick_q, tick_d;
    logic [NUM_CH-1:0]            sel;
    logic [NUM_CH-1:0]            accept;

    // One-hot decode of the load target; out-of-range channels select nothing
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel[i] = (int'(load_ch_i) == i);
        end
    end

    // Ready only blocks when the addressed channel already holds an unapplied divisor
    assign load_ready_o = ~|(sel & pending_q);
    assign accept       = sel & {NUM_CH{load_valid_i & load_ready_o}};

    // Per-channel next state: sync clears phase, disabled channels idle, running channels count
    always_comb begin
        cnt_d     = cnt_q;
        div_d     = div_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        clk_d     = clk_q;
        tick_d    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (accept[i]) begin
                shadow_d[i]  = load_div_i;
                pending_d[i] = 1'b1;
            end
            if (sync_i) begin
                cnt_d[i] = '0;
                clk_d[i] = 1'b0;
                if (accept[i]) begin
                    div_d[i]     = load_div_i;
                    pending_d[i] = 1'b0;
                end else if (pending_q[i]) begin
                    div_d[i]     = shadow_q[i];
                    pending_d[i] = 1'b0;
                end
            end else if (div_q[i] == '0) begin
                // Disabled: no boundary to wait for, so a pending divisor lands right away
                cnt_d[i] = '0;
                clk_d[i] = 1'b0;
                if (pending_q[i]) begin
                    div_d[i]     = shadow_q[i];
                    pending_d[i] = 1'b0;
                end
            end else if (en_i) begin
                if (cnt_q[i] == div_q[i] - CNT_W'(1)) begin
                    cnt_d[i] = '0;
                    if (pending_q[i]) begin
                        div_d[i]     = shadow_q[i];
                        pending_d[i] = 1'b0;
                    end
                    if (pending_q[i] && (shadow_q[i] == '0)) begin
                        clk_d[i] = 1'b0;
                    end else begin
                        clk_d[i]  = ~clk_q[i];
                        tick_d[i] = ~clk_q[i];
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // State registers with asynchronous reset to the default divisor
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            div_q     <= {NUM_CH{CNT_W'(DEFAULT_DIV)}};
            shadow_q  <= '0;
            pending_q <= '0;
            clk_q     <= '0;
            tick_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out_o = clk_q;
    assign tick_o    = tick_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// tb/tb_clk_div_bank.sv - directed self-checking bench for clk_div_bank
module tb_clk_div_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sync;
    logic        load_valid;
    logic [1:0]  load_ch;
    logic [15:0] load_div;
    logic        load_ready;
    logic [3:0]  clk_out;
    logic [3:0]  tick;

    int total  = 0;
    int passed = 0;
    int hi;
    int tk;

    clk_div_bank #(
        .NUM_CH(4), .CNT_W(16), .DEFAULT_DIV(1), .CH_W(2)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .sync_i(sync),
        .load_valid_i(load_valid), .load_ch_i(load_ch), .load_div_i(load_div),
        .load_ready_o(load_ready), .clk_out_o(clk_out), .tick_o(tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; sync = 1'b0;
        load_valid = 1'b0; load_ch = 2'd0; load_div = 16'd0;
        #2;
        chk("rst_clk", 32'(clk_out), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_ready", 32'(load_ready), 32'h1);
        step();
        chk("rst_hold_clk", 32'(clk_out), 32'h0);
        rst = 1'b0;

        // defaults: divide-by-2 on every channel
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("div2_clk", 32'(clk_out), (k % 2) ? 32'hF : 32'h0);
            chk("div2_tick", 32'(tick), (k % 2) ? 32'hF : 32'h0);
        end

        // ch2 <- 5 while running at 1
        load_valid = 1'b1; load_ch = 2'd2; load_div = 16'd5;
        chk("ld2_ready_pre", 32'(load_ready), 32'h1);
        step();
        load_valid = 1'b0;
        chk("ld2_ready_pend", 32'(load_ready), 32'h0);
        step();
        chk("ld2_ready_post", 32'(load_ready), 32'h1);
        step_n(4);
        chk("ld2_e10_clk", 32'(clk_out), 32'h0);
        chk("ld2_e10_tick", 32'(tick), 32'h0);
        step();
        chk("ld2_e11_clk", 32'(clk_out), 32'hF);
        chk("ld2_e11_tick", 32'(tick), 32'hF);
        step();
        chk("ld2_e12_clk", 32'(clk_out), 32'h4);
        chk("ld2_e12_tick", 32'(tick), 32'h0);
        hi = 0; tk = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            hi += int'(clk_out[2]);
            tk += int'(tick[2]);
        end
        chk("ld2_high_cnt", 32'(hi), 32'd5);
        chk("ld2_tick_cnt", 32'(tk), 32'd1);

        // sync with simultaneous load ch1 <- 8
        sync = 1'b1; load_valid = 1'b1; load_ch = 2'd1; load_div = 16'd8;
        step();
        sync = 1'b0; load_valid = 1'b0;
        chk("sync1_clk", 32'(clk_out), 32'h0);
        chk("sync1_tick", 32'(tick), 32'h0);
        chk("sync1_ready", 32'(load_ready), 32'h1);

        // ch1 <- 3 at cnt 0 of a D=8 half-period
        load_valid = 1'b1; load_div = 16'd3;
        step();
        load_valid = 1'b0;
        chk("ld1_ready_pend", 32'(load_ready), 32'h0);
        hi = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            hi += int'(clk_out[1]);
        end
        chk("ld1_no_runt", 32'(hi), 32'd0);
        chk("ld1_ready_still", 32'(load_ready), 32'h0);
        step();
        chk("ld1_rise_clk", 32'(clk_out[1]), 32'h1);
        chk("ld1_rise_tick", 32'(tick[1]), 32'h1);
        chk("ld1_ready_back", 32'(load_ready), 32'h1);
        step_n(2);
        chk("ld1_high3", 32'(clk_out[1]), 32'h1);
        step();
        chk("ld1_fall", 32'(clk_out[1]), 32'h0);
        step_n(3);
        chk("ld1_rise2_clk", 32'(clk_out[1]), 32'h1);
        chk("ld1_rise2_tick", 32'(tick[1]), 32'h1);

        // ch0 <- 0, then <- 4
        load_valid = 1'b1; load_ch = 2'd0; load_div = 16'd0;
        step();
        load_valid = 1'b0;
        chk("ld0_last_high", 32'(clk_out[0]), 32'h1);
        chk("ld0_ready_pend", 32'(load_ready), 32'h0);
        step();
        chk("ld0_stop_clk", 32'(clk_out[0]), 32'h0);
        chk("ld0_stop_tick", 32'(tick[0]), 32'h0);
        chk("ld0_ready", 32'(load_ready), 32'h1);
        step_n(2);
        chk("ld0_idle_clk", 32'(clk_out[0]), 32'h0);
        chk("ld0_idle_tick", 32'(tick[0]), 32'h0);
        load_valid = 1'b1; load_div = 16'd4;
        step();
        load_valid = 1'b0;
        step_n(4);
        chk("ld4_low", 32'(clk_out[0]), 32'h0);
        step();
        chk("ld4_rise_clk", 32'(clk_out[0]), 32'h1);
        chk("ld4_rise_tick", 32'(tick[0]), 32'h1);
        step();
        chk("ld4_tick_once", 32'(tick[0]), 32'h0);
        chk("ld4_high", 32'(clk_out[0]), 32'h1);
        step_n(3);
        chk("ld4_fall", 32'(clk_out[0]), 32'h0);
        step_n(4);
        chk("ld4_rise2_clk", 32'(clk_out[0]), 32'h1);
        chk("ld4_rise2_tick", 32'(tick[0]), 32'h1);

        // enable low for 7 cycles with ch0 at cnt 2 of a high half-period
        step_n(2);
        en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("en_freeze_clk", 32'(clk_out[0]), 32'h1);
            chk("en_freeze_tick", 32'(tick), 32'h0);
        end
        en = 1'b1;
        step();
        chk("en_resume_hold", 32'(clk_out[0]), 32'h1);
        step();
        chk("en_resume_fall", 32'(clk_out[0]), 32'h0);

        // program D = {2,3,4,5} on ch0..ch3
        load_valid = 1'b1; load_ch = 2'd0; load_div = 16'd2;
        step();
        load_ch = 2'd2; load_div = 16'd4;
        step();
        load_ch = 2'd3; load_div = 16'd5;
        step();
        load_valid = 1'b0;
        step_n(13);
        chk("prog_ready", 32'(load_ready), 32'h1);

        // sync together with load ch3 <- 6
        sync = 1'b1; load_valid = 1'b1; load_ch = 2'd3; load_div = 16'd6;
        step();
        sync = 1'b0; load_valid = 1'b0;
        chk("sync2_clk", 32'(clk_out), 32'h0);
        chk("sync2_tick", 32'(tick), 32'h0);
        step_n(2);
        chk("al_e2_clk", 32'(clk_out), 32'h1);
        chk("al_e2_tick", 32'(tick), 32'h1);
        step();
        chk("al_e3_clk", 32'(clk_out), 32'h3);
        chk("al_e3_tick", 32'(tick), 32'h2);
        step();
        chk("al_e4_clk", 32'(clk_out), 32'h6);
        chk("al_e4_tick", 32'(tick), 32'h4);
        step();
        chk("al_e5_clk", 32'(clk_out), 32'h6);
        chk("al_e5_tick", 32'(tick), 32'h0);
        step();
        chk("al_e6_clk", 32'(clk_out), 32'hD);
        chk("al_e6_tick", 32'(tick), 32'h9);
        step_n(6);
        chk("ch3_fall", 32'(clk_out[3]), 32'h0);
        step_n(6);
        chk("ch3_rise_clk", 32'(clk_out[3]), 32'h1);
        chk("ch3_rise_tick", 32'(tick[3]), 32'h1);

        // asynchronous reset with a pending load outstanding
        load_valid = 1'b1; load_ch = 2'd1; load_div = 16'd9;
        step();
        load_valid = 1'b0;
        chk("pre_rst_pend", 32'(load_ready), 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_clk", 32'(clk_out), 32'h0);
        chk("arst_tick", 32'(tick), 32'h0);
        chk("arst_ready", 32'(load_ready), 32'h1);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_clk", 32'(clk_out), 32'hF);
        chk("post_rst_tick", 32'(tick), 32'hF);
        step();
        chk("post_rst_clk2", 32'(clk_out), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Parametrised successor to the fixed divide-by-2 clock divider.
- Generates NUM_CH independent divided square-wave outputs plus single-cycle tick enables from one system clock.
- Each channel's half-period is runtime-programmable through a valid/ready load port, with glitch-free (boundary-aligned) divisor updates.
- Sits between the board clock and slow consumers: display scan, debouncers, blink/timer logic.

Parameters:
- NUM_CH, 4, number of divider channels (1..16).
- CNT_W, 16, width of half-period divisor and per-channel counter.
- DEFAULT_DIV, 1, reset half-period for every channel (1 = divide-by-2).
- CH_W, 2, width of LOAD_CH; must be >= clog2(NUM_CH), minimum 1.

Ports:
- CLK  in  1  system clock; all logic is on its rising edge.
- RST  in  1  asynchronous reset, active-high.
- EN  in  1  global count enable; when low, all counters and outputs freeze.
- SYNC  in  1  single-cycle phase realign of all channels.
- LOAD_VALID  in  1  divisor load request.
- LOAD_CH  in  CH_W  target channel of the load.
- LOAD_DIV  in  CNT_W  new half-period in CLK cycles; 0 disables the channel.
- LOAD_READY  out  1  load is accepted when LOAD_VALID & LOAD_READY.
- CLK_OUT  out  NUM_CH  divided square waves, registered.
- TICK  out  NUM_CH  one-CLK pulse per output period, registered.

Behaviour:
- Reset (async assert, sync deassert is the caller's job):
  - CLK_OUT = 0, TICK = 0, all counters = 0.
  - div[i] = DEFAULT_DIV, pending[i] = 0, LOAD_READY = 1.
- Per-channel counter, with D = div[i] >= 1 and EN = 1:
  - Counter counts 0..D-1. At cnt == D-1: CLK_OUT[i] toggles, cnt <= 0.
  - Output period is 2*D cycles with exactly 50% duty.
  - TICK[i] = 1 for exactly the one cycle in which CLK_OUT[i] goes 0->1; 0 otherwise.
  - D = 1 toggles every cycle (divide-by-2, TICK every 2nd cycle).
- D = 0 (channel disabled): CLK_OUT[i] forced 0, TICK[i] = 0, cnt held 0.
- EN = 0:
  - Counters and CLK_OUT hold their values; TICK = 0.
  - Loads are still accepted; SYNC still acts.
- Load handshake:
  - LOAD_READY = ~pending[LOAD_CH] (combinational from LOAD_CH). It is 1 if LOAD_CH >= NUM_CH.
  - On accept to a valid channel: shadow[ch] <= LOAD_DIV, pending[ch] <= 1.
  - An accepted load to a channel >= NUM_CH is discarded.
- Pending apply (glitch-free):
  - shadow is copied to div and pending cleared at the next toggle boundary of that channel (cnt == D-1 with EN = 1), together with cnt <= 0.
  - The new half-period governs the very next half-period.
  - If the channel is disabled (D = 0), the pending load applies on the cycle after accept. Counting from cnt 0 then begins on the following cycle, with CLK_OUT starting at 0.
  - Loading 0 into a running channel: at the boundary, CLK_OUT[i] <= 0 (instead of toggling), TICK = 0, and the channel stops.
- SYNC = 1 for one cycle:
  - Next cycle, all cnt = 0, all CLK_OUT = 0, TICK = 0.
  - All pending loads apply immediately.
  - SYNC held high keeps channels in this cleared state.
- Simultaneous events:
  - SYNC with an accepted load: the load takes effect immediately in the same SYNC update.
  - A boundary in the same cycle as an accept to that channel: the old pending value (none, since READY = 0 when pending) is applied. The new value becomes pending for the next boundary.
- Reset mid-operation: everything returns to reset values at once; pending loads are lost.
- Widths: the counter compare uses the full CNT_W bits. A divisor of 2^CNT_W-1 gives a period of 2*(2^CNT_W-1) cycles without overflow.

Test Plan:
- Reset release, defaults (DEFAULT_DIV = 1), EN = 1 -> every CLK_OUT toggles each cycle (period 2), TICK[i] high every 2nd cycle coincident with the rising edge of CLK_OUT.
- Load ch2 with 5 while running at 1 -> LOAD_READY low for 1 cycle. After the next boundary, ch2 has period 10 cycles (5 high, 5 low) and exactly one TICK per 10 cycles; other channels unaffected.
- Load ch1 with 3 at cnt 0 of a D = 8 half-period -> the current half-period completes at 8 cycles with no runt pulse. Subsequent half-periods are 3 cycles; LOAD_READY for ch1 is 0 until the boundary.
- Load ch0 with 0, then 4 -> CLK_OUT[0] goes low at the boundary and stays low with no TICK. After loading 4, output resumes from low with period 8.
- EN low for 7 cycles mid-half-period on D = 4 -> outputs and counters freeze, TICK = 0. On EN high, the remaining count resumes with no extra toggle.
- SYNC pulse with channels at D = {2,3,4,5} in random phase, plus a load of 6 to ch3 in the same cycle -> all CLK_OUT = 0 next cycle. Channels restart aligned; ch3 runs with period 12. RST asserted mid-run restores all defaults asynchronously.
